// File: rtl/mul_seq_approx_if.sv
// Operand/result handshake bundle for the iterative approximate multiplier.
// The master drives operands and result acceptance; the slave is the multiplier.
interface mul_seq_approx_if #(
    parameter int unsigned W = 4
);
    logic           in_valid;
    logic           in_ready;
    logic           mode_approx;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           out_valid;
    logic           out_ready;
    logic [2*W-1:0] po;

    modport master (
        output in_valid, mode_approx, a, b, out_ready,
        input  in_ready, out_valid, po
    );

    modport slave (
        input  in_valid, mode_approx, a, b, out_ready,
        output in_ready, out_valid, po
    );
endinterface

// File: rtl/mul_seq_approx.sv
// Radix-2 shift-add unsigned multiplier, one multiplier bit per cycle, with an
// optional approximate mode that drops partial-product columns [TRUNC-1:0].
module mul_seq_approx #(
    parameter int unsigned W     = 4,
    parameter int unsigned TRUNC = 3,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    mul_seq_approx_if.slave  bus,
    output logic [CNT_W-1:0] op_count
);
    localparam int unsigned CW = $clog2(W);
    localparam logic [2*W-1:0] LOW_COLS = ~({(2*W){1'b1}} << TRUNC);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t         state, state_n;
    logic [W-1:0]   a_q, b_q;
    logic           mode_q;
    logic [2*W-1:0] acc, po_q, mask, pp;
    logic [CW-1:0]  cnt;
    logic           last_bit;

    assign last_bit = (cnt == CW'(W - 1));

    // Masking the shifted row drops exactly the a[j]&b[i] terms with i+j < TRUNC.
    always_comb begin
        mask = mode_q ? ~LOW_COLS : '1;
        pp   = '0;
        if (b_q[cnt])
            pp = ({{W{1'b0}}, a_q} << cnt) & mask;
    end

    always_comb begin
        state_n       = state;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        case (state)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid)
                    state_n = BUSY;
            end
            BUSY: begin
                if (last_bit)
                    state_n = DONE;
            end
            DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready)
                    state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            mode_q   <= 1'b0;
            acc      <= '0;
            cnt      <= '0;
            po_q     <= '0;
            op_count <= '0;
        end else begin
            state <= state_n;
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_q    <= bus.a;
                        b_q    <= bus.b;
                        mode_q <= bus.mode_approx;
                        acc    <= '0;
                        cnt    <= '0;
                    end
                end
                BUSY: begin
                    acc <= acc + pp;
                    cnt <= cnt + 1'b1;
                    if (last_bit)
                        po_q <= acc + pp;
                end
                DONE: begin
                    if (bus.out_ready && (op_count != '1))
                        op_count <= op_count + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.po = po_q;
endmodule

// File: tb/tb_mul_seq_approx.sv
// Directed bench for mul_seq_approx: one TRUNC=3 instance and one TRUNC=0
// instance driven with identical stimulus, checked against a bitwise column model.
module tb_mul_seq_approx;
    localparam int unsigned W = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid, mode_approx, out_ready;
    logic [3:0] a, b;
    logic [15:0] op_count0, op_count1;

    int n_assert = 0;
    int n_fail   = 0;

    mul_seq_approx_if #(.W(W)) bus0 ();
    mul_seq_approx_if #(.W(W)) bus1 ();

    assign bus0.in_valid    = in_valid;
    assign bus0.mode_approx = mode_approx;
    assign bus0.a           = a;
    assign bus0.b           = b;
    assign bus0.out_ready   = out_ready;
    assign bus1.in_valid    = in_valid;
    assign bus1.mode_approx = mode_approx;
    assign bus1.a           = a;
    assign bus1.b           = b;
    assign bus1.out_ready   = out_ready;

    mul_seq_approx #(.W(W), .TRUNC(3), .CNT_W(16)) u_dut (
        .clk(clk), .rst(rst), .bus(bus0), .op_count(op_count0)
    );

    mul_seq_approx #(.W(W), .TRUNC(0), .CNT_W(16)) u_dut_t0 (
        .clk(clk), .rst(rst), .bus(bus1), .op_count(op_count1)
    );

    always #5 clk = ~clk;

    function automatic int model(input int av, input int bv, input bit md, input int tr);
        int s = 0;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                if (((bv >> i) & 1) == 1 && ((av >> j) & 1) == 1 && !(md && (i + j) < tr))
                    s += (1 << (i + j));
        return s;
    endfunction

    task automatic check(input string tag, input int obs, input int exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents an operand pair and returns once it has been accepted.
    task automatic start(input int av, input int bv, input bit md);
        int guard = 0;
        while (bus0.in_ready !== 1'b1 && guard < 20) begin
            step();
            guard++;
        end
        a = 4'(av);
        b = 4'(bv);
        mode_approx = md;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        a = 4'hx;
        b = 4'hx;
        mode_approx = 1'bx;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (bus0.out_valid !== 1'b1 && lat < 20) begin
            step();
            lat++;
        end
    endtask

    task automatic handoff();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic random_handoff();
        int guard = 0;
        bit r;
        do begin
            r = 1'($urandom_range(0, 1));
            if (guard > 30) r = 1'b1;
            out_ready = r;
            step();
            guard++;
        end while (!r);
        out_ready = 1'b0;
    endtask

    initial begin
        int lat;
        int po_hold;
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        mode_approx = 1'b0;
        a = '0;
        b = '0;
        step();
        step();
        rst = 1'b0;
        check("reset_in_ready", bus0.in_ready, 1);
        check("reset_out_valid", bus0.out_valid, 0);
        check("reset_po", bus0.po, 0);
        check("reset_op_count", op_count0, 0);

        // exact 11*13 with latency
        start(11, 13, 1'b0);
        wait_done(lat);
        check("exact_latency", lat, 4);
        check("exact_11x13", bus0.po, 143);
        handoff();
        check("op_count_after_first", op_count0, 1);
        check("in_ready_after_handoff", bus0.in_ready, 1);
        check("out_valid_after_handoff", bus0.out_valid, 0);

        // approximate
        start(11, 13, 1'b1);
        wait_done(lat);
        check("approx_11x13", bus0.po, 136);
        check("approx_11x13_trunc0", bus1.po, 143);
        handoff();
        start(15, 15, 1'b1);
        wait_done(lat);
        check("approx_15x15", bus0.po, 208);
        handoff();

        // zero corners keep full latency
        start(0, 15, 1'b0);
        wait_done(lat);
        check("zero_a_latency", lat, 4);
        check("zero_a", bus0.po, 0);
        handoff();
        start(15, 0, 1'b0);
        wait_done(lat);
        check("zero_b_latency", lat, 4);
        check("zero_b", bus0.po, 0);
        handoff();
        check("op_count_five", op_count0, 5);

        // back-pressure with ignored input pulses
        start(9, 7, 1'b0);
        wait_done(lat);
        po_hold = 63;
        for (int c = 0; c < 5; c++) begin
            in_valid = c[0];
            a = 4'd3;
            b = 4'd5;
            mode_approx = 1'b1;
            check("bp_out_valid", bus0.out_valid, 1);
            check("bp_po", bus0.po, po_hold);
            check("bp_in_ready", bus0.in_ready, 0);
            step();
        end
        in_valid = 1'b0;
        check("bp_po_final", bus0.po, po_hold);
        handoff();
        check("bp_idle_after", bus0.in_ready, 1);
        check("bp_retained_po", bus0.po, po_hold);
        check("op_count_six", op_count0, 6);

        // reset during the second BUSY cycle
        start(13, 11, 1'b0);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrst_in_ready", bus0.in_ready, 1);
        check("midrst_out_valid", bus0.out_valid, 0);
        check("midrst_op_count", op_count0, 0);
        start(6, 7, 1'b0);
        wait_done(lat);
        check("post_rst_6x7", bus0.po, 42);
        handoff();

        // exhaustive, both modes, both truncation builds
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int md = 0; md < 2; md++) begin
            for (int ai = 0; ai < 16; ai++) begin
                for (int bi = 0; bi < 16; bi++) begin
                    start(ai, bi, 1'(md));
                    wait_done(lat);
                    check($sformatf("ex_t3_a%0d_b%0d_m%0d", ai, bi, md), bus0.po,
                          model(ai, bi, 1'(md), 3));
                    check($sformatf("ex_t0_a%0d_b%0d_m%0d", ai, bi, md), bus1.po, ai * bi);
                    random_handoff();
                end
            end
        end
        check("op_count_512", op_count0, 512);
        check("op_count_512_t0", op_count1, 512);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
